l2_tag_ctrl: RTL

L2_TAG_CTRL -- requirements
Module: l2_tag_ctrl

---
 rtl/hpu_pkg.sv | 17 +
 rtl/l2_tag_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/hpu_pkg.sv
// Shared enums for the L2 tag controller: request op codes and FSM states.
package hpu_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_FILL   = 2'd1,
        OP_INVAL  = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/l2_tag_ctrl.sv
// L2 tag controller: lookup/fill/invalidate against an external tag array,
// registered response with ready/valid backpressure, and a flush-all sweep.
module l2_tag_ctrl
    import hpu_pkg::*;
#(
    parameter int TAG_W = 17,
    parameter int AWTH  = 3,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_vld_i,
    output logic             req_rdy_o,
    input  logic [1:0]       req_op_i,
    input  logic [AWTH-1:0]  req_idx_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_vld_o,
    input  logic             rsp_rdy_i,
    output logic             rsp_hit_o,
    output logic [TAG_W:0]   rsp_old_o,
    input  logic             flush_i,
    output logic             flush_busy_o,
    output logic             flush_done_o,
    output logic             arr_wen_o,
    output logic [AWTH-1:0]  arr_waddr_o,
    output logic [TAG_W:0]   arr_wdata_o,
    output logic [AWTH-1:0]  arr_raddr_o,
    input  logic [TAG_W:0]   arr_rdata_i
);

    localparam logic [AWTH-1:0] LAST_IDX = AWTH'(DEPTH - 1);
    localparam logic [TAG_W:0]  INV_ENT  = {1'b1, {TAG_W{1'b0}}};

    state_e            state_q, state_d;
    logic [AWTH-1:0]   cnt_q, cnt_d;
    logic              rsp_vld_q, rsp_vld_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic [TAG_W:0]    rsp_old_q, rsp_old_d;
    logic              accept;
    logic              hit;

    assign req_rdy_o = (state_q == ST_IDLE) && !flush_i && (!rsp_vld_q || rsp_rdy_i);
    // Gate with reset so no array write can leak out while rst_i is low.
    assign accept    = req_vld_i && req_rdy_o && rst_i;

    assign arr_raddr_o = (state_q == ST_FLUSH) ? cnt_q : req_idx_i;
    assign hit         = !arr_rdata_i[TAG_W] && (arr_rdata_i[TAG_W-1:0] == req_tag_i);

    assign rsp_vld_o    = rsp_vld_q;
    assign rsp_hit_o    = rsp_hit_q;
    assign rsp_old_o    = rsp_old_q;
    assign flush_busy_o = (state_q == ST_FLUSH) || (state_q == ST_DONE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        arr_wen_o    = 1'b0;
        arr_waddr_o  = req_idx_i;
        arr_wdata_o  = {1'b0, req_tag_i};
        flush_done_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else if (accept) begin
                    case (op_e'(req_op_i))
                        OP_FILL:  arr_wen_o = 1'b1;
                        OP_INVAL: begin
                            arr_wen_o   = hit;
                            arr_wdata_o = INV_ENT;
                        end
                        default:  arr_wen_o = 1'b0;
                    endcase
                end
            end
            ST_FLUSH: begin
                arr_wen_o   = 1'b1;
                arr_waddr_o = cnt_q;
                arr_wdata_o = INV_ENT;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
            end
            ST_DONE: begin
                flush_done_o = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response slot is independent of the FSM, so it survives a flush.
    always_comb begin
        rsp_vld_d = rsp_vld_q;
        rsp_hit_d = rsp_hit_q;
        rsp_old_d = rsp_old_q;
        if (accept) begin
            rsp_vld_d = 1'b1;
            rsp_hit_d = hit;
            rsp_old_d = arr_rdata_i;
        end else if (rsp_rdy_i) begin
            rsp_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_hit_q <= 1'b0;
            rsp_old_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_hit_q <= rsp_hit_d;
            rsp_old_q <= rsp_old_d;
        end
    end

endmodule
